// File: rtl/cache_fill_arbiter.sv
// ---------------------------------------------------------------------------
// cache_fill_arbiter
//
// Shares one multi-cycle main memory between the I-cache and D-cache miss
// handlers. One block fill is serviced at a time. Word reads are issued back
// to back, and the returning words are steered into the granted cache's data
// array. A one-cycle done pulse then tells the requester to write its tag.
//
// Optional feature (compile-time macro):
//   ARB_ROUND_ROBIN_EN : on a tie, the side that was not granted last wins.
//                        When undefined, the D-cache always wins ties.
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   i_miss / i_addr          I-cache fill request and missing byte address
//   d_miss / d_addr          D-cache fill request and missing byte address
//   mem_en / mem_addr        one word read request per cycle (byte address)
//   mem_data_in / mem_valid  read data returned in issue order
//   fill_data / fill_word    word and word index to write into the data array
//   i_fill_we / d_fill_we    data-array write enable of the granted side
//   fill_base                block base address of the current fill (tag write)
//   i_done / d_done          one-cycle block-complete pulse
//   busy                     a fill is in progress (FILL or DONE)
// ---------------------------------------------------------------------------
module cache_fill_arbiter #(
    parameter int AWIDTH    = 16,
    parameter int DWIDTH    = 16,
    parameter int BLK_WORDS = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_miss,
    input  logic [AWIDTH-1:0]            i_addr,
    input  logic                         d_miss,
    input  logic [AWIDTH-1:0]            d_addr,
    output logic                         mem_en,
    output logic [AWIDTH-1:0]            mem_addr,
    input  logic [DWIDTH-1:0]            mem_data_in,
    input  logic                         mem_valid,
    output logic [DWIDTH-1:0]            fill_data,
    output logic [$clog2(BLK_WORDS)-1:0] fill_word,
    output logic                         i_fill_we,
    output logic                         d_fill_we,
    output logic [AWIDTH-1:0]            fill_base,
    output logic                         i_done,
    output logic                         d_done,
    output logic                         busy
);

    localparam int WW = $clog2(BLK_WORDS);
    localparam int IW = WW + 1;
    // Clears the byte-within-block bits; a block is 2*BLK_WORDS bytes.
    localparam logic [AWIDTH-1:0] BASE_MASK = ~AWIDTH'(2 * BLK_WORDS - 1);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_e;
    typedef enum logic {SIDE_I, SIDE_D} side_e;

    state_e            state_q, state_d;
    side_e             grant_q, grant_d;
    side_e             pick;
    logic [AWIDTH-1:0] base_q, base_d;
    logic [IW-1:0]     issue_q, issue_d;   // one wider so it can reach BLK_WORDS
    logic [WW-1:0]     recv_q, recv_d;

    // ---------------- arbitration ----------------
`ifdef ARB_ROUND_ROBIN_EN
    side_e last_grant_q;

    always_comb begin
        if (i_miss && d_miss) begin
            pick = (last_grant_q == SIDE_I) ? SIDE_D : SIDE_I;
        end else begin
            pick = d_miss ? SIDE_D : SIDE_I;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= SIDE_I;
        end else if (state_q == IDLE && (i_miss || d_miss)) begin
            last_grant_q <= pick;
        end
    end
`else
    always_comb pick = d_miss ? SIDE_D : SIDE_I;
`endif

    // ---------------- state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= SIDE_I;
            base_q  <= '0;
            issue_q <= '0;
            recv_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            base_q  <= base_d;
            issue_q <= issue_d;
            recv_q  <= recv_d;
        end
    end

    // ---------------- next state and outputs ----------------
    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case statement can infer a latch.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        base_d    = base_q;
        issue_d   = issue_q;
        recv_d    = recv_q;
        mem_en    = 1'b0;
        mem_addr  = '0;
        fill_data = '0;
        fill_word = '0;
        i_fill_we = 1'b0;
        d_fill_we = 1'b0;
        i_done    = 1'b0;
        d_done    = 1'b0;

        unique case (state_q)
            IDLE: begin
                issue_d = '0;
                recv_d  = '0;
                if (i_miss || d_miss) begin
                    grant_d = pick;
                    base_d  = ((pick == SIDE_D) ? d_addr : i_addr) & BASE_MASK;
                    state_d = FILL;
                end
            end

            FILL: begin
                // Issue side: one read per cycle until the whole block is out.
                if (issue_q < IW'(BLK_WORDS)) begin
                    mem_en   = 1'b1;
                    mem_addr = base_q + (AWIDTH'(issue_q) << 1);
                    issue_d  = issue_q + IW'(1);
                end
                // Receive side runs concurrently; words come back in order.
                if (mem_valid) begin
                    fill_data = mem_data_in;
                    fill_word = recv_q;
                    i_fill_we = (grant_q == SIDE_I);
                    d_fill_we = (grant_q == SIDE_D);
                    recv_d    = recv_q + WW'(1);
                    if (recv_q == WW'(BLK_WORDS - 1)) begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                i_done  = (grant_q == SIDE_I);
                d_done  = (grant_q == SIDE_D);
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign fill_base = busy ? base_q : '0;

endmodule
